// File: rtl/vrf_pkg.sv
// Shared defaults and the vector register type for the vector register file.
package vrf_pkg;
  localparam int VRF_LANES      = 4;
  localparam int VRF_LANE_WIDTH = 8;
  localparam int VRF_REG_COUNT  = 8;
  localparam int VRF_SEL_BITS   = 3;

  typedef logic [VRF_LANES-1:0][VRF_LANE_WIDTH-1:0] vreg_t;
endpackage

// File: rtl/vrf_row.sv
// One vector register: a row of LANES lanes, each written only when its mask bit is set.
module vrf_row
  import vrf_pkg::*;
#(
  parameter int LANE_WIDTH = VRF_LANE_WIDTH,
  parameter int LANES      = VRF_LANES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wrEn,
  input  logic [LANES-1:0]            wrMask,
  input  logic [LANES*LANE_WIDTH-1:0] wrData,
  output logic [LANES*LANE_WIDTH-1:0] dataOut
);

  logic [LANES*LANE_WIDTH-1:0] data_q;
  logic [LANES*LANE_WIDTH-1:0] data_d;

  // Lane-masked merge of incoming data with the stored row
  always_comb begin
    data_d = data_q;
    if (wrEn) begin
      for (int i = 0; i < LANES; i++) begin
        if (wrMask[i]) begin
          data_d[i*LANE_WIDTH +: LANE_WIDTH] = wrData[i*LANE_WIDTH +: LANE_WIDTH];
        end else begin
          data_d[i*LANE_WIDTH +: LANE_WIDTH] = data_q[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end else begin
      data_d = data_q;
    end
  end

  // Row storage with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign dataOut = data_q;

endmodule

// File: rtl/vector_reg_file.sv
// Vector register file: two combinational read ports, one lane-masked write port and an issue scoreboard.
// Optional macro VRF_BYPASS_EN forwards same-cycle writeback data to reads and hazard checks.
module vector_reg_file
  import vrf_pkg::*;
#(
  parameter int LANES      = VRF_LANES,
  parameter int LANE_WIDTH = VRF_LANE_WIDTH,
  parameter int REG_COUNT  = VRF_REG_COUNT,
  parameter int SEL_BITS   = VRF_SEL_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_BITS-1:0]         rSel1,
  input  logic [SEL_BITS-1:0]         rSel2,
  output logic [LANES*LANE_WIDTH-1:0] rd1Out,
  output logic [LANES*LANE_WIDTH-1:0] rd2Out,
  input  logic                        wrEn,
  input  logic [SEL_BITS-1:0]         wrSel,
  input  logic [LANES-1:0]            wrMask,
  input  logic [LANES*LANE_WIDTH-1:0] wrData,
  input  logic                        issueEn,
  input  logic [SEL_BITS-1:0]         issueSel,
  output logic                        stall,
  output logic [REG_COUNT-1:0]        busyVec
);

  localparam int DW = LANES * LANE_WIDTH;

  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic [REG_COUNT-1:0] wr_dec;
  logic [REG_COUNT-1:0] iss_dec;
  logic [REG_COUNT-1:0] hz_vec;
  logic [DW-1:0]        row_data [REG_COUNT];
  logic [DW-1:0]        rd1_mux;
  logic [DW-1:0]        rd2_mux;

  // Selector values at or above REG_COUNT decode to nothing, so they never hit a row.
  function automatic logic sel_hit(input logic [REG_COUNT-1:0] v, input logic [SEL_BITS-1:0] s);
    logic h;
    h = 1'b0;
    for (int n = 0; n < REG_COUNT; n++) begin
      if (s == SEL_BITS'(n)) begin
        h = v[n];
      end else begin
        h = h;
      end
    end
    return h;
  endfunction

`ifdef VRF_BYPASS_EN
  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] base, input logic [DW-1:0] data,
                                               input logic [LANES-1:0] mask);
    logic [DW-1:0] r;
    r = base;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        r[i*LANE_WIDTH +: LANE_WIDTH] = data[i*LANE_WIDTH +: LANE_WIDTH];
      end else begin
        r[i*LANE_WIDTH +: LANE_WIDTH] = base[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    return r;
  endfunction
`endif

  // One-hot decode of write and issue destinations
  always_comb begin
    wr_dec  = '0;
    iss_dec = '0;
    for (int n = 0; n < REG_COUNT; n++) begin
      wr_dec[n]  = (wrSel == SEL_BITS'(n));
      iss_dec[n] = (issueSel == SEL_BITS'(n));
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_row
    vrf_row #(
      .LANE_WIDTH(LANE_WIDTH),
      .LANES     (LANES)
    ) u_row (
      .clk    (clk),
      .reset  (reset),
      .wrEn   (wrEn & wr_dec[g]),
      .wrMask (wrMask),
      .wrData (wrData),
      .dataOut(row_data[g])
    );
  end

  // Read port muxes, with optional forwarding of the in-flight writeback
  always_comb begin
    rd1_mux = '0;
    rd2_mux = '0;
    for (int n = 0; n < REG_COUNT; n++) begin
      if (rSel1 == SEL_BITS'(n)) begin
        rd1_mux = row_data[n];
      end else begin
        rd1_mux = rd1_mux;
      end
      if (rSel2 == SEL_BITS'(n)) begin
        rd2_mux = row_data[n];
      end else begin
        rd2_mux = rd2_mux;
      end
    end
`ifdef VRF_BYPASS_EN
    if (wrEn && (|wr_dec) && (rSel1 == wrSel)) begin
      rd1_mux = lane_merge(rd1_mux, wrData, wrMask);
    end else begin
      rd1_mux = rd1_mux;
    end
    if (wrEn && (|wr_dec) && (rSel2 == wrSel)) begin
      rd2_mux = lane_merge(rd2_mux, wrData, wrMask);
    end else begin
      rd2_mux = rd2_mux;
    end
`endif
  end

  // Hazard vector: a register being written back this cycle is not a hazard when forwarding
  always_comb begin
`ifdef VRF_BYPASS_EN
    hz_vec = busy_q & ~(wr_dec & {REG_COUNT{wrEn}});
`else
    hz_vec = busy_q;
`endif
    stall = issueEn & (sel_hit(hz_vec, rSel1) | sel_hit(hz_vec, rSel2) | sel_hit(hz_vec, issueSel));
  end

  // Scoreboard next state: clear on writeback first, so an accepted issue wins on the same register
  always_comb begin
    busy_d = busy_q;
    if (wrEn) begin
      busy_d = busy_d & ~wr_dec;
    end else begin
      busy_d = busy_d;
    end
    if (issueEn && !stall) begin
      busy_d = busy_d | iss_dec;
    end else begin
      busy_d = busy_d;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rd1Out  = rd1_mux;
  assign rd2Out  = rd2_mux;
  assign busyVec = busy_q;

endmodule

// File: tb/tb_vector_reg_file.sv
// Directed self-checking bench for vector_reg_file (default build and VRF_BYPASS_EN build).
module tb_vector_reg_file;
  import vrf_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  rSel1, rSel2, wrSel, issueSel;
  logic [31:0] rd1Out, rd2Out, wrData;
  logic        wrEn, issueEn, stall;
  logic [3:0]  wrMask;
  logic [7:0]  busyVec;

  logic [2:0]  rSel1_6, rSel2_6, wrSel_6, issueSel_6;
  logic [31:0] rd1Out_6, rd2Out_6, wrData_6;
  logic        wrEn_6, issueEn_6, stall_6;
  logic [3:0]  wrMask_6;
  logic [5:0]  busyVec_6;

  int total = 0;
  int bad   = 0;
  logic bypass;
  vreg_t exp_v;

  vector_reg_file dut (
    .clk(clk), .reset(reset), .rSel1(rSel1), .rSel2(rSel2), .rd1Out(rd1Out), .rd2Out(rd2Out),
    .wrEn(wrEn), .wrSel(wrSel), .wrMask(wrMask), .wrData(wrData),
    .issueEn(issueEn), .issueSel(issueSel), .stall(stall), .busyVec(busyVec)
  );

  vector_reg_file #(.REG_COUNT(6), .SEL_BITS(3)) dut6 (
    .clk(clk), .reset(reset), .rSel1(rSel1_6), .rSel2(rSel2_6), .rd1Out(rd1Out_6), .rd2Out(rd2Out_6),
    .wrEn(wrEn_6), .wrSel(wrSel_6), .wrMask(wrMask_6), .wrData(wrData_6),
    .issueEn(issueEn_6), .issueSel(issueSel_6), .stall(stall_6), .busyVec(busyVec_6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef VRF_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    reset = 1'b1;
    rSel1 = 3'd0; rSel2 = 3'd0; wrEn = 1'b0; wrSel = 3'd0; wrMask = 4'h0; wrData = 32'h0;
    issueEn = 1'b0; issueSel = 3'd0;
    rSel1_6 = 3'd0; rSel2_6 = 3'd0; wrEn_6 = 1'b0; wrSel_6 = 3'd0; wrMask_6 = 4'h0;
    wrData_6 = 32'h0; issueEn_6 = 1'b0; issueSel_6 = 3'd0;
    tick();
    reset = 1'b0;
    #1;
    check("rst_rd1", 64'(rd1Out), 64'h0);
    check("rst_rd2", 64'(rd2Out), 64'h0);
    check("rst_busy", 64'(busyVec), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);

    // Masked write to reg 2
    wrEn = 1'b1; wrSel = 3'd2; wrMask = 4'b1111; wrData = 32'h4433_2211;
    tick();
    wrMask = 4'b0101; wrData = 32'hAABB_CCDD;
    tick();
    wrEn = 1'b0; rSel1 = 3'd2; rSel2 = 3'd3;
    #1;
    exp_v = 32'h4433_2211;
    exp_v[0] = 8'hDD;
    exp_v[2] = 8'hBB;
    check("mask_rd1", 64'(rd1Out), 64'(exp_v));
    check("mask_other_reg", 64'(rd2Out), 64'h0);

    // Scoreboard: issue reg 3, hazard, writeback with empty mask
    rSel1 = 3'd0; rSel2 = 3'd0; issueEn = 1'b1; issueSel = 3'd3;
    #1;
    check("sb_issue_stall", 64'(stall), 64'h0);
    tick();
    check("sb_busy_set", 64'(busyVec), 64'h08);
    issueSel = 3'd4; rSel1 = 3'd3;
    #1;
    check("sb_hazard_stall", 64'(stall), 64'h1);
    tick();
    check("sb_busy_hold", 64'(busyVec), 64'h08);
    issueEn = 1'b0; wrEn = 1'b1; wrSel = 3'd3; wrMask = 4'b0000; wrData = 32'hFFFF_FFFF;
    tick();
    wrEn = 1'b0;
    #1;
    check("sb_busy_clear", 64'(busyVec), 64'h0);
    check("sb_nomask_data", 64'(rd1Out), 64'h0);

    // Set wins over clear on reg 5
    rSel1 = 3'd0; rSel2 = 3'd0;
    issueEn = 1'b1; issueSel = 3'd5; wrEn = 1'b1; wrSel = 3'd5; wrMask = 4'hF; wrData = 32'h1234_5678;
    tick();
    issueEn = 1'b0; wrEn = 1'b0;
    #1;
    check("set_over_clear", 64'(busyVec), 64'h20);
    wrEn = 1'b1; wrMask = 4'h0;
    tick();
    wrEn = 1'b0;
    #1;
    check("soc_cleanup", 64'(busyVec), 64'h0);

    // Bypass on reg 1
    wrEn = 1'b1; wrSel = 3'd1; wrMask = 4'b0011; wrData = 32'hFFFF_FFFF; rSel2 = 3'd1;
    #1;
    check("byp_same_cycle", 64'(rd2Out), bypass ? 64'h0000_FFFF : 64'h0);
    tick();
    wrEn = 1'b0;
    #1;
    check("byp_next_cycle", 64'(rd2Out), 64'h0000_FFFF);

    // Hazard forwarding: reg 6 busy, written back while being read by an issuing instruction
    rSel2 = 3'd0; issueEn = 1'b1; issueSel = 3'd6;
    tick();
    issueSel = 3'd7; rSel1 = 3'd6; wrEn = 1'b1; wrSel = 3'd6; wrMask = 4'h0;
    #1;
    check("byp_hz_stall", 64'(stall), bypass ? 64'h0 : 64'h1);
    tick();
    check("byp_hz_busy", 64'(busyVec), bypass ? 64'h80 : 64'h0);
    issueEn = 1'b0; wrSel = 3'd7; rSel1 = 3'd0;
    tick();
    wrEn = 1'b0;

    // Fill scoreboard then reset mid-operation
    issueEn = 1'b1;
    for (int n = 0; n < 8; n++) begin
      issueSel = 3'(n); rSel1 = 3'(n); rSel2 = 3'(n);
      tick();
    end
    check("fill_busy", 64'(busyVec), 64'hFF);
    issueEn = 1'b0; reset = 1'b1; wrEn = 1'b1; wrSel = 3'd2; wrMask = 4'hF; wrData = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0; wrEn = 1'b0; rSel1 = 3'd2; rSel2 = 3'd5;
    #1;
    check("midrst_rd1", 64'(rd1Out), 64'h0);
    check("midrst_rd2", 64'(rd2Out), 64'h0);
    check("midrst_busy", 64'(busyVec), 64'h0);
    check("midrst_stall", 64'(stall), 64'h0);

    // Out-of-range selectors on the 6-register instance
    wrEn_6 = 1'b1; wrSel_6 = 3'd5; wrMask_6 = 4'hF; wrData_6 = 32'h5555_5555;
    tick();
    wrSel_6 = 3'd7; wrData_6 = 32'hFFFF_FFFF; rSel1_6 = 3'd7; rSel2_6 = 3'd5;
    issueEn_6 = 1'b1; issueSel_6 = 3'd7;
    #1;
    check("oor_rd1_during_wr", 64'(rd1Out_6), 64'h0);
    check("oor_stall", 64'(stall_6), 64'h0);
    tick();
    wrEn_6 = 1'b0; issueEn_6 = 1'b0;
    #1;
    check("oor_busy", 64'(busyVec_6), 64'h0);
    check("oor_rd1", 64'(rd1Out_6), 64'h0);
    check("oor_reg5", 64'(rd2Out_6), 64'h5555_5555);
    for (int n = 0; n < 5; n++) begin
      rSel1_6 = 3'(n);
      #1;
      check("oor_reg_unchanged", 64'(rd1Out_6), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
